// File: rtl/pc_pkg.sv
// Shared definitions for the next-PC unit: default widths, reset vector,
// FSM state encoding and the next-PC source select codes.
package pc_pkg;

    localparam int          PC_W         = 8;
    localparam int          RAS_DEPTH    = 4;
    localparam logic [7:0]  RESET_VECTOR = 8'h00;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_VECTOR = 3'd0,
        SEL_HOLD   = 3'd1,
        SEL_SEQ    = 3'd2,
        SEL_BRANCH = 3'd3,
        SEL_JUMP   = 3'd4,
        SEL_CALL   = 3'd5,
        SEL_RETURN = 3'd6
    } pc_sel_e;

    // Every source except HOLD loads the pc register.
    function automatic logic sel_writes_pc(input pc_sel_e sel);
        return sel != SEL_HOLD;
    endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// Control/status bundle between the fetch datapath (master) and the
// next-PC unit (slave).
interface pc_next_if #(
    parameter int PC_W    = 8,
    parameter int DEPTH_W = 3
);
    logic [PC_W-1:0]    pc;
    logic               stall;
    logic               br_taken;
    logic [PC_W-1:0]    br_target;
    logic               jmp;
    logic [PC_W-1:0]    jmp_target;
    logic               call;
    logic [PC_W-1:0]    call_target;
    logic               ret;
    logic               halt;
    logic [PC_W-1:0]    next_pc;
    logic               pcwrite;
    logic [DEPTH_W-1:0] ras_depth;
    logic               ras_overflow;
    logic               ras_underflow;
    logic               halted;

    modport master (
        output pc, stall, br_taken, br_target, jmp, jmp_target,
               call, call_target, ret, halt,
        input  next_pc, pcwrite, ras_depth, ras_overflow, ras_underflow, halted
    );

    modport slave (
        input  pc, stall, br_taken, br_target, jmp, jmp_target,
               call, call_target, ret, halt,
        output next_pc, pcwrite, ras_depth, ras_overflow, ras_underflow, halted
    );
endinterface

// File: rtl/pc_next_unit_ras_stack.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry and keeps the depth saturated; a pop while empty is a no-op apart
// from the sticky underflow flag. Push and pop are never requested together.
module ras_stack #(
    parameter int PC_W      = 8,
    parameter int RAS_DEPTH = 4,
    localparam int PTR_W    = $clog2(RAS_DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [PC_W-1:0]  push_data_i,
    output logic [PC_W-1:0]  top_o,
    output logic [CNT_W-1:0] depth_o,
    output logic             empty_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] depth_q, depth_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             write_en;
    logic             full;

    assign full        = (depth_q == FULL_COUNT);
    assign empty_o     = (depth_q == '0);
    assign top_ptr     = wr_ptr_q - PTR_W'(1);
    assign top_o       = mem_q[top_ptr];
    assign depth_o     = depth_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

    // Next pointer, occupancy and sticky flags for this cycle's push or pop.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        depth_d     = depth_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        write_en    = 1'b0;
        if (pop_i) begin
            if (empty_o) begin
                underflow_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q - PTR_W'(1);
                depth_d  = depth_q - CNT_W'(1);
            end
        end else if (push_i) begin
            write_en = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                depth_d = depth_q + CNT_W'(1);
            end
        end
    end

    // Pointer, occupancy and flag registers; reset empties the stack.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (write_en && !rst) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC generator feeding the pc register. Picks the next pc from
// sequential/branch/jump/call/return sources, owns the return-address stack
// and a RESET/RUN/HALT FSM that decides whether the pc may move at all.
module pc_next_unit #(
    parameter int              PC_W         = pc_pkg::PC_W,
    parameter int              RAS_DEPTH    = pc_pkg::RAS_DEPTH,
    parameter logic [PC_W-1:0] RESET_VECTOR = pc_pkg::RESET_VECTOR
) (
    input  logic         clk,
    input  logic         rst,
    pc_next_if.slave     pc_bus
);

    import pc_pkg::*;

    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    state_e           state_q, state_d;
    pc_sel_e          sel;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_empty;
    logic [PC_W-1:0]  ras_top;
    logic [PC_W-1:0]  pc_plus1;
    logic [CNT_W-1:0] ras_count;

    // Sequential successor wraps naturally at the pc width.
    assign pc_plus1 = pc_bus.pc + PC_W'(1);

    ras_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_plus1),
        .top_o       (ras_top),
        .depth_o     (ras_count),
        .empty_o     (ras_empty),
        .overflow_o  (pc_bus.ras_overflow),
        .underflow_o (pc_bus.ras_underflow)
    );

    // FSM next state and source selection; ret beats call beats jmp beats branch.
    always_comb begin
        state_d  = state_q;
        sel      = SEL_HOLD;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        unique case (state_q)
            S_RESET: begin
                sel     = SEL_VECTOR;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!pc_bus.stall) begin
                    if (pc_bus.ret) begin
                        ras_pop = 1'b1;
                        sel     = ras_empty ? SEL_SEQ : SEL_RETURN;
                    end else if (pc_bus.call) begin
                        ras_push = 1'b1;
                        sel      = SEL_CALL;
                    end else if (pc_bus.jmp) begin
                        sel = SEL_JUMP;
                    end else if (pc_bus.br_taken) begin
                        sel = SEL_BRANCH;
                    end else begin
                        sel = SEL_SEQ;
                    end
                    if (pc_bus.halt) begin
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: begin
                sel = SEL_HOLD;
            end
            default: begin
                sel     = SEL_VECTOR;
                state_d = S_RESET;
            end
        endcase
    end

    // Next-pc mux driven by the selected source.
    always_comb begin
        pc_bus.next_pc = pc_bus.pc;
        unique case (sel)
            SEL_VECTOR: pc_bus.next_pc = RESET_VECTOR;
            SEL_HOLD:   pc_bus.next_pc = pc_bus.pc;
            SEL_SEQ:    pc_bus.next_pc = pc_plus1;
            SEL_BRANCH: pc_bus.next_pc = pc_bus.br_target;
            SEL_JUMP:   pc_bus.next_pc = pc_bus.jmp_target;
            SEL_CALL:   pc_bus.next_pc = pc_bus.call_target;
            SEL_RETURN: pc_bus.next_pc = ras_top;
            default:    pc_bus.next_pc = pc_bus.pc;
        endcase
        pc_bus.pcwrite = sel_writes_pc(sel);
    end

    // FSM state register; reset always restarts from the reset vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    assign pc_bus.halted    = (state_q == S_HALT);
    assign pc_bus.ras_depth = ras_count;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// queue-based behavioural model of the next-PC rules.
module tb_pc_next_unit;

    localparam int RAS_DEPTH = 4;
    localparam int M_RESET   = 0;
    localparam int M_RUN     = 1;
    localparam int M_HALT    = 2;

    logic clk = 1'b0;
    logic rst;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] capNext;
    logic       capWrite;

    pc_next_if #(.PC_W(8), .DEPTH_W(3)) bus ();

    pc_next_unit #(
        .PC_W         (8),
        .RAS_DEPTH    (RAS_DEPTH),
        .RESET_VECTOR (8'h00)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pc_bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rt, input logic cl,
                                 input logic jp, input logic br, input logic hl,
                                 input logic [7:0] brT, input logic [7:0] jpT,
                                 input logic [7:0] clT);
        bus.stall       = st;
        bus.ret         = rt;
        bus.call        = cl;
        bus.jmp         = jp;
        bus.br_taken    = br;
        bus.halt        = hl;
        bus.br_target   = brT;
        bus.jmp_target  = jpT;
        bus.call_target = clT;
    endtask

    task automatic clearInputs();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    // Wait for the mid-cycle sampling point and remember what pc will load.
    task automatic atNegedge();
        @(negedge clk);
        capNext  = bus.next_pc;
        capWrite = bus.pcwrite;
    endtask

    // Clock edge: the bench's pc register loads when pcwrite was high.
    task automatic advance();
        @(posedge clk);
        #1;
        if (capWrite === 1'b1) bus.pc = capNext;
    endtask

    // Behavioural model: state, RAS as a queue, sticky flags; compared every cycle.
    int  mState;
    int  mRas[$];
    int  mOvf;
    int  mUnf;
    bit  modelValid = 1'b0;

    always @(negedge clk) begin : compareProc
        int expNext;
        int expWrite;
        int pcv;
        if (!modelValid && rst === 1'b1) begin
            mState = M_RESET;
            mRas.delete();
            mOvf = 0;
            mUnf = 0;
            modelValid = 1'b1;
        end
        if (modelValid) begin
            pcv = int'(bus.pc);
            expNext  = pcv;
            expWrite = 0;
            if (mState == M_RESET) begin
                expNext  = 0;
                expWrite = 1;
            end else if (mState == M_RUN && !bus.stall) begin
                expWrite = 1;
                if (bus.ret) expNext = (mRas.size() > 0) ? mRas[$] : (pcv + 1) % 256;
                else if (bus.call) expNext = int'(bus.call_target);
                else if (bus.jmp) expNext = int'(bus.jmp_target);
                else if (bus.br_taken) expNext = int'(bus.br_target);
                else expNext = (pcv + 1) % 256;
            end
            checkOutput("model_next_pc", int'(bus.next_pc), expNext);
            checkOutput("model_pcwrite", int'(bus.pcwrite), expWrite);
            checkOutput("model_ras_depth", int'(bus.ras_depth), mRas.size());
            checkOutput("model_overflow", int'(bus.ras_overflow), mOvf);
            checkOutput("model_underflow", int'(bus.ras_underflow), mUnf);
            checkOutput("model_halted", int'(bus.halted), (mState == M_HALT) ? 1 : 0);

            if (rst) begin
                mState = M_RESET;
                mRas.delete();
                mOvf = 0;
                mUnf = 0;
            end else if (mState == M_RESET) begin
                mState = M_RUN;
            end else if (mState == M_RUN && !bus.stall) begin
                if (bus.ret) begin
                    if (mRas.size() == 0) mUnf = 1;
                    else void'(mRas.pop_back());
                end else if (bus.call) begin
                    mRas.push_back((pcv + 1) % 256);
                    if (mRas.size() > RAS_DEPTH) begin
                        void'(mRas.pop_front());
                        mOvf = 1;
                    end
                end
                if (bus.halt) mState = M_HALT;
            end
        end
    end

    // Directed scenarios with literal expectations, then randomized traffic.
    initial begin
        logic [7:0] retExp [3];
        logic [7:0] lifoExp [4];
        rst    = 1'b1;
        bus.pc = 8'h00;
        clearInputs();
        atNegedge(); advance();
        atNegedge(); advance();
        rst = 1'b0;

        atNegedge();
        checkOutput("reset_vector", int'(bus.next_pc), 8'h00);
        checkOutput("reset_pcwrite", int'(bus.pcwrite), 1);
        checkOutput("reset_depth", int'(bus.ras_depth), 0);
        advance();
        for (int i = 0; i < 3; i++) begin
            atNegedge();
            checkOutput("seq_after_reset", int'(bus.next_pc), i + 1);
            advance();
        end

        bus.pc = 8'hFF;
        atNegedge();
        checkOutput("wrap_seq", int'(bus.next_pc), 8'h00);
        advance();
        bus.pc = 8'hFF;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h40);
        atNegedge();
        checkOutput("wrap_call_target", int'(bus.next_pc), 8'h40);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        atNegedge();
        checkOutput("wrap_pushed_value", int'(bus.next_pc), 8'h00);
        advance();
        clearInputs();

        bus.pc = 8'h10;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h40);
        atNegedge();
        checkOutput("call_target", int'(bus.next_pc), 8'h40);
        advance();
        clearInputs();
        atNegedge();
        checkOutput("call_depth", int'(bus.ras_depth), 1);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        atNegedge();
        checkOutput("ret_addr", int'(bus.next_pc), 8'h11);
        advance();
        clearInputs();
        atNegedge();
        checkOutput("ret_depth", int'(bus.ras_depth), 0);
        advance();

        bus.pc = 8'h20;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'(8'h50 + 8'(k * 16)));
            atNegedge(); advance();
        end
        retExp[0] = 8'h61; retExp[1] = 8'h51; retExp[2] = 8'h21;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            atNegedge();
            checkOutput("nested_lifo", int'(bus.next_pc), int'(retExp[k]));
            advance();
        end

        bus.pc = 8'h80;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'(8'h90 + 8'(k * 16)));
            atNegedge(); advance();
        end
        clearInputs();
        atNegedge();
        checkOutput("overflow_flag", int'(bus.ras_overflow), 1);
        checkOutput("overflow_depth", int'(bus.ras_depth), 4);
        advance();
        lifoExp[0] = 8'hC1; lifoExp[1] = 8'hB1; lifoExp[2] = 8'hA1; lifoExp[3] = 8'h91;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            atNegedge();
            checkOutput("overflow_ret", int'(bus.next_pc), int'(lifoExp[k]));
            advance();
        end
        atNegedge();
        checkOutput("underflow_next", int'(bus.next_pc), 8'h92);
        advance();
        clearInputs();
        atNegedge();
        checkOutput("underflow_flag", int'(bus.ras_underflow), 1);
        checkOutput("underflow_depth", int'(bus.ras_depth), 0);
        advance();

        bus.pc = 8'h30;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h35);
        atNegedge(); advance();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h88, 8'h77);
        atNegedge();
        checkOutput("priority_ret", int'(bus.next_pc), 8'h31);
        advance();
        clearInputs();
        atNegedge();
        checkOutput("priority_no_push", int'(bus.ras_depth), 0);
        advance();

        bus.pc = 8'h30;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h35);
        atNegedge(); advance();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h88, 8'h00);
        atNegedge();
        checkOutput("stall_hold_pc", int'(bus.next_pc), 8'h35);
        checkOutput("stall_pcwrite", int'(bus.pcwrite), 0);
        advance();
        clearInputs();
        atNegedge();
        checkOutput("stall_depth", int'(bus.ras_depth), 1);
        advance();

        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                          $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                          $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3,
                          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255)));
            rst = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 9) == 0) bus.pc = 8'($urandom_range(0, 255));
            atNegedge(); advance();
        end

        clearInputs();
        rst = 1'b1;
        atNegedge(); advance();
        rst = 1'b0;
        atNegedge(); advance();

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h20, 8'h00);
        atNegedge();
        checkOutput("halt_jmp_next", int'(bus.next_pc), 8'h20);
        checkOutput("halt_jmp_write", int'(bus.pcwrite), 1);
        advance();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h55, 8'h00);
        for (int k = 0; k < 3; k++) begin
            atNegedge();
            checkOutput("halted_flag", int'(bus.halted), 1);
            checkOutput("halted_pcwrite", int'(bus.pcwrite), 0);
            checkOutput("halted_next", int'(bus.next_pc), 8'h20);
            advance();
        end
        rst = 1'b1;
        atNegedge(); advance();
        rst = 1'b0;
        clearInputs();
        atNegedge();
        checkOutput("halt_reset_next", int'(bus.next_pc), 8'h00);
        checkOutput("halt_reset_halted", int'(bus.halted), 0);
        checkOutput("halt_reset_write", int'(bus.pcwrite), 1);
        advance();
        atNegedge(); advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
